dw_result_collector: RTL and testbench
======================================

# dw_result_collector

Drain stage for the depthwise systolic array. It takes the per-cycle `result` bus of `NUM_KCELLS` 32-bit sums, discards pipeline-fill and row-ramp samples, and requantizes each lane to signed 8 bits. It then packs the lanes into one output word and buffers it in a FIFO with a valid/ready handshake toward the output buffer. The array cannot stall, so capture never back-pressures; overrun is flagged.

## Interface
- `DATA_WIDTH`, 8: output lane width
- `OUT_DATA_WIDTH`, 32: input lane width (array accumulator width)
- `NUM_KCELLS`, 3: lanes per sample
- `FILL_LAT`, 4: cycles from `start` to the first array sample
- `IN_COLS`, 34: samples per row in the stream, including ramp
- `SKIP_COLS`, 2: leading samples per row discarded (`NUM_KCELLS-1`)
- `OUT_ROWS`, 32: rows per frame
- `FIFO_DEPTH`, 16: output FIFO entries; must be a power of two
- `clk` in 1: the block's single clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: single-cycle pulse that begins a frame
- `shift_amt` in 5: requant right shift, sampled on `start`
- `result` in `NUM_KCELLS*OUT_DATA_WIDTH`: array output; lane k is bits [k*32 +: 32]
- `out_ready` in 1: downstream accepts a word
- `out_valid` out 1: FIFO head is valid
- `out_data` out `NUM_KCELLS*DATA_WIDTH`: packed lanes; lane k is bits [k*8 +: 8]
- `out_last` out 1: marks the final word of the frame
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse at frame completion
- `overflow` out 1: sticky; a sample arrived while the FIFO was full

## Operation
- FSM states: IDLE, FILL, CAPTURE, DRAIN.
- IDLE → FILL on `start`. On the same edge: latch `shift_amt`, clear `overflow`, clear the counters.
- FILL: count `FILL_LAT` cycles, then go to CAPTURE.
- CAPTURE: `col` counts 0..`IN_COLS-1`, then wraps and increments `row`.
  - A sample is valid when `col >= SKIP_COLS`.
  - After the edge with `row = OUT_ROWS-1` and `col = IN_COLS-1`, go to DRAIN.
- DRAIN: wait for the FIFO to be empty and the requant stage to be empty, then pulse `done` and return to IDLE.
- `start` is ignored while `busy` is high.
- Requant, per lane, all signed:
  - If `s = shift_amt > 0`: compute `r = (x + (1 << (s-1))) >>> s`. Otherwise `r = x`.
  - Do the add at 33 bits so it cannot wrap.
  - Saturate `r` to [-128, 127].
- FIFO write when full: the word is dropped and `overflow` sets. The FIFO contents are left untouched.
- FIFO write and read in the same cycle: always permitted, including when the FIFO is full.
- `out_last` is stored with each FIFO word. It is set only on the word from the final valid sample.
- Frame size is `OUT_ROWS*(IN_COLS-SKIP_COLS)` words.
- `reset` mid-frame: return to IDLE, flush the FIFO and the requant stage, no `done` pulse.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0, `overflow` 0.
- The first array sample is on the (`FILL_LAT`+1)th rising edge after the edge that sampled `start`.
- One sample per cycle during CAPTURE; there is no stall.
- Latency: a sample captured at edge E is written to the FIFO at edge E+1. `out_valid` is high after E+1 when the FIFO was empty.
- A word transfers on each edge with `out_valid && out_ready`. `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- `done` is asserted for the single cycle after the edge at which the last word transfers. `busy` falls on that same edge.
- `overflow` rises on the edge of the dropped write.

## Configuration
- `DW_RESULT_RELU_EN` defined: negative lane values clamp to 0 before saturation, so the output range is [0, 127].
- `DW_RESULT_RELU_EN` undefined: the output range is [-128, 127].
- Handshake and timing are identical either way.

## Structure
- Shared package `dw_pkg`:
  - width constants `DATA_WIDTH` and `OUT_DATA_WIDTH`
  - the FSM state enum
  - a `sat_shift` function implementing the requant rule
- One sub-module, `dw_out_fifo`: a synchronous FIFO of `NUM_KCELLS*DATA_WIDTH+1` bits by `FIFO_DEPTH`, with full/empty flags and show-ahead read.

## Test plan
- Basic frame, with `IN_COLS`=4, `SKIP_COLS`=2, `OUT_ROWS`=2, `shift_amt`=0, `out_ready`=1, and lanes set to col index:
  - exactly 4 words, with lanes equal to 2, 3, 2, 3
  - `out_last` on the 4th word only
  - `done` pulses once
- Requant with `shift_amt`=4, inputs 24, -24, 7:
  - outputs 2, -1, 0 (round half-up)
  - inputs 100000 and -100000 → 127 and -128
- ReLU under `DW_RESULT_RELU_EN`: input -24 → 0 and 24 → 2 at shift 4; without the macro → -1 and 2.
- Back-pressure with `out_ready`=0 for the whole frame, `FIFO_DEPTH`=16, and 20 valid samples:
  - the first 16 words are retained in order
  - `overflow`=1 from the 17th sample onward
  - after releasing `out_ready`, 16 words drain, then `done` pulses
- `start` pulsed during CAPTURE: ignored, with no counter reset.
- Asynchronous `reset` mid-CAPTURE:
  - all outputs go to their reset values immediately
  - a following `start` produces a complete, correct frame.

Source files
------------

// File: rtl/dw_pkg.sv
// dw_pkg: shared widths, FSM states and the requant helper for dw_result_collector.
// DW_RESULT_RELU_EN clamps negative lanes to zero before saturation.
package dw_pkg;
    localparam int DATA_WIDTH     = 8;
    localparam int OUT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DRAIN} state_t;

    localparam logic signed [OUT_DATA_WIDTH:0] SAT_HI = (OUT_DATA_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [OUT_DATA_WIDTH:0] SAT_LO = ~SAT_HI;

    function automatic logic [DATA_WIDTH-1:0] sat_shift(
        input logic signed [OUT_DATA_WIDTH-1:0] x,
        input logic [4:0] s
    );
        logic signed [OUT_DATA_WIDTH:0] w_r;
        // one guard bit so the half-up rounding bias cannot wrap
        w_r = {x[OUT_DATA_WIDTH-1], x};
        if (s != 5'd0)
            w_r = (w_r + $signed((OUT_DATA_WIDTH+1)'(1) << (s - 5'd1))) >>> s;
`ifdef DW_RESULT_RELU_EN
        if (w_r[OUT_DATA_WIDTH])
            w_r = '0;
`endif
        return (w_r > SAT_HI) ? DATA_WIDTH'(SAT_HI) :
               (w_r < SAT_LO) ? DATA_WIDTH'(SAT_LO) : w_r[DATA_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/dw_out_fifo.sv
// dw_out_fifo: show-ahead synchronous FIFO; a write while full is accepted only alongside a read.
module dw_out_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             w_wr, w_rd;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = o_count == (AW+1)'(DEPTH);
    assign o_empty   = o_count == '0;
    assign w_rd      = i_rd_en && !o_empty;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/dw_result_collector.sv
// dw_result_collector: drains the depthwise array result bus, requantizes each lane and queues
// packed words toward the output buffer. DW_RESULT_RELU_EN selects the ReLU output range.
module dw_result_collector #(
    parameter int DATA_WIDTH     = dw_pkg::DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = dw_pkg::OUT_DATA_WIDTH,
    parameter int NUM_KCELLS     = 3,
    parameter int FILL_LAT       = 4,
    parameter int IN_COLS        = 34,
    parameter int SKIP_COLS      = 2,
    parameter int OUT_ROWS       = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [4:0]                            shift_amt,
    input  logic [NUM_KCELLS*OUT_DATA_WIDTH-1:0]  result,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [NUM_KCELLS*DATA_WIDTH-1:0]      out_data,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);
    import dw_pkg::*;

    localparam int LW = NUM_KCELLS*DATA_WIDTH;
    localparam int CW = $clog2(IN_COLS+1);
    localparam int RW = $clog2(OUT_ROWS+1);
    localparam int FW = $clog2(FILL_LAT+1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t        r_state;
    logic [4:0]    r_shift;
    logic [FW-1:0] r_fill;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_q_valid, r_q_last, r_done, r_overflow;
    logic [LW-1:0] r_q_data;
    logic [LW-1:0] w_req;
    logic [LW:0]   w_head;
    logic [AW:0]   w_count;
    logic          w_capture, w_last_sample, w_pop, w_full, w_empty, w_drained;

    for (genvar k = 0; k < NUM_KCELLS; k++) begin : g_lane
        assign w_req[k*DATA_WIDTH +: DATA_WIDTH] = sat_shift(result[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH], r_shift);
    end

    assign w_capture     = (r_state == CAPTURE) && (r_col >= CW'(SKIP_COLS));
    assign w_last_sample = (r_state == CAPTURE) && (r_row == RW'(OUT_ROWS-1)) && (r_col == CW'(IN_COLS-1));
    assign w_pop         = !w_empty && out_ready;
    // frame ends on the edge that pops the final word, so done lines up with that transfer
    assign w_drained     = !r_q_valid && (w_empty || (w_count == (AW+1)'(1) && w_pop));

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_head[LW-1:0];
    assign out_last  = !w_empty && w_head[LW];
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign overflow  = r_overflow;

    dw_out_fifo #(.WIDTH(LW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (r_q_valid),
        .i_wr_data ({r_q_last, r_q_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_fill     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_q_valid  <= 1'b0;
            r_q_last   <= 1'b0;
            r_q_data   <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_q_valid <= w_capture;
            r_q_data  <= w_req;
            r_q_last  <= w_last_sample;
            if (r_q_valid && w_full && !w_pop) r_overflow <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_state    <= FILL;
                    r_shift    <= shift_amt;
                    r_overflow <= 1'b0;
                    r_fill     <= '0;
                    r_col      <= '0;
                    r_row      <= '0;
                end
                FILL: if (r_fill == FW'(FILL_LAT-1)) r_state <= CAPTURE;
                      else r_fill <= r_fill + 1'b1;
                CAPTURE: begin
                    r_col <= (r_col == CW'(IN_COLS-1)) ? '0 : r_col + 1'b1;
                    if (r_col == CW'(IN_COLS-1)) r_row <= r_row + 1'b1;
                    if (w_last_sample) r_state <= DRAIN;
                end
                DRAIN: if (w_drained) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dw_result_collector.sv
// tb_dw_result_collector: randomized frames checked against a behavioural requant and frame model.
module tb_dw_result_collector;
    localparam int DW = 8, ODW = 32, NK = 3, FILL_LAT = 4;
    localparam int IN_COLS = 12, SKIP_COLS = 2, OUT_ROWS = 2, DEPTH = 16;
    localparam int LW = NK*DW, NS = IN_COLS*OUT_ROWS, NV = (IN_COLS-SKIP_COLS)*OUT_ROWS;
`ifdef DW_RESULT_RELU_EN
    localparam logic [7:0] NEG24 = 8'h00, NEGBIG = 8'h00;
`else
    localparam logic [7:0] NEG24 = 8'hFF, NEGBIG = 8'h80;
`endif

    logic clk = 1'b0;
    logic reset, start, out_ready, out_valid, out_last, busy, done, overflow;
    logic [4:0] shift_amt;
    logic [NK*ODW-1:0] result;
    logic [LW-1:0] out_data;

    logic [NK*ODW-1:0] stim [NS];
    logic [LW:0] exp_q [$];
    logic [LW:0] mon_e;
    logic [LW-1:0] hold_d;
    logic hold_l;
    bit ph = 0, hold_v = 0;
    int n_chk = 0, n_fail = 0, n_done = 0, cyc = 0, last_xfer = -10;

    always #5 clk = ~clk;

    dw_result_collector #(
        .DATA_WIDTH(DW), .OUT_DATA_WIDTH(ODW), .NUM_KCELLS(NK), .FILL_LAT(FILL_LAT),
        .IN_COLS(IN_COLS), .SKIP_COLS(SKIP_COLS), .OUT_ROWS(OUT_ROWS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .shift_amt(shift_amt), .result(result),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // round half-up division by 2^s with floor semantics, then clamp to the lane range
    function automatic logic [7:0] rq(input int x, input int s);
        longint n, d, q;
        n = longint'(x) + ((s > 0) ? (longint'(1) << (s-1)) : 64'sd0);
        d = longint'(1) << s;
        q = n / d;
        if (n % d != 0 && n < 0) q--;
`ifdef DW_RESULT_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    function automatic void build(input int s, input int keep);
        int v;
        logic [LW:0] w;
        v = 0;
        for (int i = 0; i < NS; i++) begin
            if (i % IN_COLS >= SKIP_COLS) begin
                if (v < keep) begin
                    for (int k = 0; k < NK; k++) w[k*DW +: DW] = rq($signed(stim[i][k*ODW +: ODW]), s);
                    w[LW] = (v == NV-1);
                    exp_q.push_back(w);
                end
                v++;
            end
        end
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < NS; i++) begin
            for (int k = 0; k < NK; k++) begin
                logic [31:0] t;
                t = $urandom;
                stim[i][k*ODW +: ODW] = ($urandom_range(0, 3) == 0) ? t : 32'($signed(t) >>> $urandom_range(4, 20));
            end
        end
    endtask

    task automatic tick(input int rm);
        @(negedge clk);
        ph = !ph;
        out_ready = (rm == 0) ? 1'b1 : (rm == 2) ? 1'b0 : (ph ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    task automatic run_frame(input logic [4:0] sh, input int rm, input int mid_start, input int abort_at, input bit chk_ovf);
        int d0, nw;
        d0 = n_done;
        tick(rm);
        start = 1'b1;
        shift_amt = sh;
        tick(rm);
        start = 1'b0;
        shift_amt = 5'($urandom);
        check("ovf_cleared", overflow, 0);
        check("busy_start", busy, 1);
        repeat (FILL_LAT) tick(rm);
        for (int i = 0; i < NS; i++) begin
            result = stim[i];
            start = (i == mid_start);
            if (i == mid_start) shift_amt = sh + 5'd3;
            if (chk_ovf) begin
                nw = 0;
                for (int j = 0; j <= i-2; j++) nw += int'(j % IN_COLS >= SKIP_COLS);
                check("ovf_track", overflow, nw > DEPTH);
            end
            if (i == abort_at) begin
                #2 reset = 1'b1;
                #1 check("rst_valid", out_valid, 0);
                check("rst_data", out_data, 0);
                check("rst_last", out_last, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_ovf", overflow, 0);
                #1 reset = 1'b0;
                hold_v = 0;
                start = 1'b0;
                result = '0;
                return;
            end
            tick(rm);
        end
        result = '0;
        start = 1'b0;
        for (int c = 0; c < 400 && n_done == d0; c++) begin
            if (rm == 2 && c == 6) begin
                check("bp_valid", out_valid, 1);
                check("bp_ovf", overflow, 1);
                rm = 0;
            end
            tick(rm);
        end
        check("done_cnt", n_done - d0, 1);
        check("words_left", exp_q.size(), 0);
        check("busy_end", busy, 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (done) begin
            n_done++;
            check("done_gap", cyc - last_xfer, 1);
            check("done_busy", busy, 0);
        end
        if (hold_v) begin
            check("hold_data", out_data, hold_d);
            check("hold_last", out_last, hold_l);
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_word", out_valid, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("word_data", out_data, mon_e[LW-1:0]);
                check("word_last", out_last, mon_e[LW]);
            end
            last_xfer = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] sh;
        int d;
        reset = 1'b1;
        start = 1'b0;
        shift_amt = '0;
        result = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_last", out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", overflow, 0);
        reset = 1'b0;

        for (int i = 0; i < NS; i++)
            for (int k = 0; k < NK; k++) stim[i][k*ODW +: ODW] = 32'(i % IN_COLS);
        build(0, NV);
        run_frame(5'd0, 0, -1, -1, 0);

        for (int i = 0; i < NS; i++) begin
            stim[i] = (i < IN_COLS) ? {32'd7, -32'sd24, 32'd24} : {32'd7, -32'sd100000, 32'd100000};
            if (i % IN_COLS >= SKIP_COLS)
                exp_q.push_back((i < IN_COLS) ? {1'b0, 8'h00, NEG24, 8'h02} : {i == NS-1, 8'h00, NEGBIG, 8'h7F});
        end
        run_frame(5'd4, 0, -1, -1, 0);

        for (int f = 0; f < 3; f++) begin
            fill_rand();
            sh = 5'($urandom_range(0, 12));
            build(sh, NV);
            run_frame(sh, 1, (f == 1) ? 5 : -1, -1, 0);
            check("ovf_none", overflow, 0);
        end

        fill_rand();
        sh = 5'($urandom_range(0, 8));
        build(sh, DEPTH);
        run_frame(sh, 2, -1, -1, 1);
        check("ovf_sticky", overflow, 1);

        fill_rand();
        sh = 5'($urandom_range(0, 8));
        build(sh, NV);
        d = n_done;
        run_frame(sh, 0, -1, 8, 0);
        exp_q.delete();
        repeat (4) tick(0);
        check("abort_no_done", n_done, d);
        check("abort_idle_valid", out_valid, 0);

        fill_rand();
        sh = 5'($urandom_range(0, 12));
        build(sh, NV);
        run_frame(sh, 1, -1, -1, 0);

        repeat (3) tick(0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
